// File: rtl/reg_fifo_pkg.sv
// rtl/reg_fifo_pkg.sv - shared helpers for the register-based FIFO
package reg_fifo_pkg;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/reg_fifo_ptr.sv
// rtl/reg_fifo_ptr.sv - wrapping FIFO pointer; wraps by natural overflow
import reg_fifo_pkg::*;

module reg_fifo_ptr #(
  parameter int PW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reg_fifo_reg.sv
// rtl/reg_fifo_reg.sv - library register: async reset, sync clear, load enable
module reg_fifo_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (clear) begin
      data_q <= RESET_VAL;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - synchronous FIFO from per-entry registers, write decode and read mux
import reg_fifo_pkg::*;

module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH) || DEPTH < 2 || WIDTH < 1) begin : g_bad_params
    $error("reg_fifo: DEPTH must be a power of two >= 2 and WIDTH >= 1");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;

  // Handshake readiness depends on occupancy only, so no valid->ready paths exist.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & !clear;
  assign count     = count_q;

  reg_fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (push),
    .ptr   (wr_ptr)
  );

  reg_fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (pop),
    .ptr   (rd_ptr)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_fifo_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_entry (
      .clock (clock),
      .reset (reset),
      .en    (wr_en && (wr_ptr == PW'(i))),
      .clear (1'b0),
      .d     (in_data),
      .q     (mem[i])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == PW'(i)) begin
        rd_word = mem[i];
      end
    end
  end

  assign out_data = out_valid ? rd_word : '0;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// tb/tb_reg_fifo.sv - scoreboard bench for reg_fifo
module tb_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] sb_q[$];

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = sb_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(n));
    check_eq({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(n != DEPTH));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    if (n == 0) check_eq({tag, ".out_data_idle"}, 32'(out_data), 32'h0);
  endtask

  // Called at posedge+1; checks mid-cycle, updates the model, returns at next posedge+1.
  task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                      input logic ordy, input logic clr);
    logic do_push;
    logic do_pop;
    logic [WIDTH-1:0] exp_word;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #3;
    check_status(tag);
    do_push = iv && (sb_q.size() < DEPTH);
    do_pop  = ordy && (sb_q.size() > 0);
    if (sb_q.size() > 0) begin
      exp_word = sb_q[0];
      check_eq({tag, ".out_data"}, 32'(out_data), 32'(exp_word));
    end
    if (clr) begin
      sb_q.delete();
    end else begin
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(d);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check_status("rst0");
    check_eq("rst0.out_data", 32'(out_data), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill, overflow attempt, drain
    step("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
    check_eq("fill.full", 32'(full), 32'h1);
    check_eq("fill.count", 32'(count), 32'h4);
    step("ovf", 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain.empty", 32'(empty), 32'h1);

    // Wrap-around with one word preloaded
    step("pre", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(i), 1'b1, 1'b0);
    check_eq("wrap.count", 32'(count), 32'h1);
    check_eq("wrap.last", 32'(out_data), 32'h09);
    step("wrap_end", 1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop while full: only the pop happens
    for (int i = 0; i < 4; i++) step("full_fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step("full_pp", 1'b1, 8'hEE, 1'b1, 1'b0);
    check_eq("full_pp.count", 32'(count), 32'h3);
    for (int i = 0; i < 3; i++) step("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear overrides push and pop
    step("clr_a", 1'b1, 8'h31, 1'b0, 1'b0);
    step("clr_b", 1'b1, 8'h32, 1'b0, 1'b0);
    step("clr", 1'b1, 8'h99, 1'b1, 1'b1);
    check_eq("clr.empty", 32'(empty), 32'h1);
    step("post_clr", 1'b1, 8'h7E, 1'b0, 1'b0);
    check_eq("post_clr.data", 32'(out_data), 32'h7E);
    step("post_clr_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: head held while consumer stalls
    step("bp_a", 1'b1, 8'hC1, 1'b0, 1'b0);
    step("bp_b", 1'b1, 8'hC2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("bp_pop0", 1'b0, 8'h00, 1'b1, 1'b0);
    step("bp_pop1", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'(($urandom & 3) != 0), 8'($urandom), 1'(($urandom & 3) != 0),
           1'($urandom_range(0, 24) == 0));
    end
    while (sb_q.size() > 0) step("rand_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset mid-burst with three words stored
    step("rb0", 1'b1, 8'h61, 1'b0, 1'b0);
    step("rb1", 1'b1, 8'h62, 1'b0, 1'b0);
    step("rb2", 1'b1, 8'h63, 1'b0, 1'b0);
    check_eq("rb.count", 32'(count), 32'h3);
    in_valid = 1'b1;
    in_data  = 8'h64;
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check_status("async_rst");
    check_eq("async_rst.out_data", 32'(out_data), 32'h0);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("after_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("after_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    step("after_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
